// File: rtl/ooo_resp_pkg.sv
// Shared types and helpers for the out-of-order read responder.
// Holds the latency LFSR step function and its tap mask.
package ooo_resp_pkg;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  // x^16+x^14+x^13+x^11+1, shifting toward the MSB
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr.
// Produces a one-hot grant and an any-request flag.
module rr_pick #(
  parameter int N = 8,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  logic done;

  always_comb begin
    grant = '0;
    done  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!done && req[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        done = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ooo_read_responder.sv
// AR/R responder returning beats out of order across IDs,
// in order within an ID, with LFSR-driven per-request latency.
module ooo_read_responder
  import ooo_resp_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          ID_WIDTH   = 4,
  parameter int          DEPTH      = 8,
  parameter int          MIN_LAT    = 0,
  parameter int          LAT_BITS   = 3,
  parameter bit          FIXED_LAT  = 1'b0,
  parameter logic [15:0] LFSR_SEED  = LFSR_RESET
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ID_WIDTH-1:0]         s_arid_i,
  input  logic                        s_arvalid_i,
  output logic                        s_arready_o,
  output logic [DATA_WIDTH-1:0]       s_rdata_o,
  output logic [ID_WIDTH-1:0]         s_rid_o,
  output logic                        s_rvalid_o,
  input  logic                        s_rready_i,
  output logic [$clog2(DEPTH+2)-1:0]  pending_o
);

  localparam int CW = $clog2(MIN_LAT + 2**LAT_BITS);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 2);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         cnt;
  } slot_t;

  slot_t                 slot_q  [DEPTH];
  logic [DEPTH-1:0]      age_q   [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] seq_q;
  logic [15:0]           lfsr_q;
  logic [AW-1:0]         rr_q;
  logic                  rvalid_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  acc;
  logic [DEPTH-1:0]      alloc_oh;
  logic                  alloc_found;
  logic [DEPTH-1:0]      elig;
  logic                  blk;
  logic [DEPTH-1:0]      grant;
  logic                  any_elig;
  logic                  load;
  slot_t                 win_slot;
  logic [AW-1:0]         win_idx;
  logic [CW-1:0]         new_cnt;
  logic [PW-1:0]         pop;

  assign s_arready_o = ~&valid_q;
  assign acc         = s_arvalid_i & s_arready_o;

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // A slot waits behind any older live slot carrying the same id
  always_comb begin
    elig = '0;
    blk  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blk = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_q[j] && age_q[j][i] &&
            slot_q[j].id == slot_q[i].id)
          blk = 1'b1;
      end
      elig[i] = valid_q[i] && (slot_q[i].cnt == '0) && !blk;
    end
  end

  rr_pick #(.N(DEPTH)) u_rr_pick (
    .req   (elig),
    .ptr   (rr_q),
    .grant (grant),
    .any   (any_elig)
  );

  assign load = (~rvalid_q | s_rready_i) & any_elig;

  always_comb begin
    win_slot = '0;
    win_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        win_slot = slot_q[i];
        win_idx  = AW'(i);
      end
    end
  end

  always_comb begin
    if (FIXED_LAT)
      new_cnt = CW'(MIN_LAT);
    else
      new_cnt = CW'(MIN_LAT) + CW'(lfsr_q[LAT_BITS-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && slot_q[i].cnt != '0)
          slot_q[i].cnt <= slot_q[i].cnt - CW'(1);
        if (load && grant[i])
          valid_q[i] <= 1'b0;
        // age column uses pre-free valid; new row starts clear
        for (int j = 0; j < DEPTH; j++) begin
          if (acc && alloc_oh[j])
            age_q[i][j] <= valid_q[i];
          if (acc && alloc_oh[i])
            age_q[i][j] <= 1'b0;
        end
        if (acc && alloc_oh[i]) begin
          valid_q[i]     <= 1'b1;
          slot_q[i].id   <= s_arid_i;
          slot_q[i].data <= seq_q;
          slot_q[i].cnt  <= new_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (acc) begin
      seq_q  <= seq_q + DATA_WIDTH'(1);
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rr_q     <= '0;
    end else if (load) begin
      rvalid_q <= 1'b1;
      rid_q    <= win_slot.id;
      rdata_q  <= win_slot.data;
      rr_q     <= win_idx + AW'(1);
    end else if (s_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  always_comb begin
    pop = PW'(rvalid_q);
    for (int i = 0; i < DEPTH; i++)
      pop = pop + PW'(valid_q[i]);
  end

  assign pending_o  = pop;
  assign s_rvalid_o = rvalid_q;
  assign s_rid_o    = rid_q;
  assign s_rdata_o  = rdata_q;

endmodule
